// File: rtl/multicycle_main_control_pkg.sv
// multicycle_main_control_pkg: state, opcode, ALUOp and mux-select encodings for the multicycle controller
package multicycle_main_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_EXEC_I    = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11
  } state_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [2:0] ALUOP_AND   = 3'd0;
  localparam logic [2:0] ALUOP_OR    = 3'd1;
  localparam logic [2:0] ALUOP_ADD   = 3'd2;
  localparam logic [2:0] ALUOP_SUB   = 3'd3;
  localparam logic [2:0] ALUOP_OP4   = 3'd4;
  localparam logic [2:0] ALUOP_OP5   = 3'd5;
  localparam logic [2:0] ALUOP_FUNCT = 3'd7;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  // FETCH doubles as the "unrecognised opcode" result
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R:                                      return S_EXEC_R;
      OP_LW, OP_SW:                              return S_MEM_ADDR;
      OP_BEQ:                                    return S_BRANCH;
      OP_J:                                      return S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI: return S_EXEC_I;
      default:                                   return S_FETCH;
    endcase
  endfunction
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    return op == OP_ANDI ? ALUOP_AND :
           op == OP_ORI  ? ALUOP_OR  :
           op == OP_XORI ? ALUOP_OP4 :
           op == OP_SLTI ? ALUOP_OP5 : ALUOP_ADD;
  endfunction
endpackage

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM sequencing fetch/decode/execute/memory/writeback with memory stalls
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter logic [2:0] RESET_ALUOP = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] ALUOp,
  output logic       illegal_op,
  output logic [3:0] state
);
  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_op_q  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
    end
  end
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:     w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    w_next = decode_next(opcode);
      S_MEM_ADDR:  w_next = r_op_q == OP_LW ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    w_next = S_R_WB;
      S_EXEC_I:    w_next = S_I_WB;
      default:     w_next = S_FETCH;
    endcase
  end
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_source     = PCSRC_ALU;
    ALUOp         = ALUOP_ADD;
    illegal_op    = 1'b0;
    state         = r_state;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = decode_next(opcode) == S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        ALUOp     = ALUOP_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        ALUOp     = imm_aluop(r_op_q);
      end
      S_I_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOp         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: state = r_state;
    endcase
    if (reset) begin
      {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write} = '0;
      {mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op} = '0;
      alu_src_b = '0;
      pc_source = '0;
      ALUOp     = RESET_ALUOP;
      state     = S_FETCH;
    end
  end
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: table-driven per-cycle checks plus latency sequences for the main control FSM
module tb_multicycle_main_control;
  import multicycle_main_control_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] ALUOp;
  logic [3:0] state;
  int         checks = 0;
  int         errors = 0;
  multicycle_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .ALUOp(ALUOp), .illegal_op(illegal_op), .state(state)
  );
  always #5 clk = ~clk;
  function automatic logic [17:0] o(input logic pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                                    input logic [1:0] asb, pcs, input logic [2:0] alu, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, alu, ill};
  endfunction
  localparam logic [17:0] E_RST = o(0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'd0, 0);
  localparam logic [17:0] E_FR  = o(1,0,0,1,0,1,0,0,0,0, 2'b01, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_FW  = o(0,0,0,1,0,0,0,0,0,0, 2'b01, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_D   = o(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_DI  = o(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'd2, 1);
  localparam logic [17:0] E_MA  = o(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_MR  = o(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_MWB = o(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_MW  = o(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_XR  = o(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'd7, 0);
  localparam logic [17:0] E_RWB = o(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_IWB = o(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'd2, 0);
  localparam logic [17:0] E_BR  = o(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'd3, 0);
  localparam logic [17:0] E_J   = o(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'd2, 0);
  function automatic logic [17:0] e_xi(input logic [2:0] alu);
    return o(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, alu, 0);
  endfunction
  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [17:0] ex;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic rst, input logic [5:0] op, input logic rdy, input logic [3:0] st, input logic [17:0] ex);
    vq.push_back('{rst, op, rdy, st, ex});
  endtask
  task automatic i_alu(input logic [5:0] op, input logic [2:0] alu);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, op, 1, S_DECODE, E_D);
    add(0, 6'd0, 1, S_EXEC_I, e_xi(alu));
    add(0, 6'd0, 1, S_I_WB, E_IWB);
  endtask
  task automatic lat(input logic [5:0] op, input int want, input string name);
    int n = 0;
    opcode = op;
    mem_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (state != S_FETCH && n < 20);
    checks++;
    if (n != want) begin
      errors++;
      $display("FAIL latency_%s: cycles=%0d expected=%0d", name, n, want);
    end
  endtask
  initial begin
    logic [17:0] act;
    add(1, 6'd0, 1, S_FETCH, E_RST);
    add(1, 6'd0, 1, S_FETCH, E_RST);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_LW, 1, S_DECODE, E_D);
    add(0, OP_SW, 1, S_MEM_ADDR, E_MA);
    add(0, OP_SW, 1, S_MEM_READ, E_MR);
    add(0, 6'd0, 1, S_MEM_WB, E_MWB);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_SW, 1, S_DECODE, E_D);
    add(0, OP_LW, 1, S_MEM_ADDR, E_MA);
    add(0, 6'd0, 0, S_MEM_WRITE, E_MW);
    add(0, 6'd0, 0, S_MEM_WRITE, E_MW);
    add(0, 6'd0, 0, S_MEM_WRITE, E_MW);
    add(0, 6'd0, 1, S_MEM_WRITE, E_MW);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_R, 1, S_DECODE, E_D);
    add(0, OP_LW, 1, S_EXEC_R, E_XR);
    add(0, 6'd0, 1, S_R_WB, E_RWB);
    i_alu(OP_XORI, 3'd4);
    i_alu(OP_SLTI, 3'd5);
    i_alu(OP_ANDI, 3'd0);
    i_alu(OP_ORI, 3'd1);
    i_alu(OP_ADDI, 3'd2);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_BEQ, 1, S_DECODE, E_D);
    add(0, 6'd0, 1, S_BRANCH, E_BR);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_J, 1, S_DECODE, E_D);
    add(0, 6'd0, 1, S_JUMP, E_J);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, 6'b111111, 1, S_DECODE, E_DI);
    add(0, 6'b111111, 0, S_FETCH, E_FW);
    add(0, 6'd0, 0, S_FETCH, E_FW);
    add(0, 6'd0, 1, S_FETCH, E_FR);
    add(0, OP_LW, 1, S_DECODE, E_D);
    add(0, 6'd0, 1, S_MEM_ADDR, E_MA);
    add(0, 6'd0, 0, S_MEM_READ, E_MR);
    add(1, 6'd0, 0, S_FETCH, E_RST);
    add(1, 6'd0, 1, S_FETCH, E_RST);
    add(0, 6'd0, 0, S_FETCH, E_FW);
    add(0, 6'd0, 0, S_FETCH, E_FW);
    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst;
      opcode = vq[i].op;
      mem_ready = vq[i].rdy;
      #1;
      act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
             reg_dst, reg_write, alu_src_a, alu_src_b, pc_source, ALUOp, illegal_op};
      checks++;
      if (state !== vq[i].st) begin
        errors++;
        $display("FAIL row%0d_state: got=%0d expected=%0d", i, state, vq[i].st);
      end
      checks++;
      if (act !== vq[i].ex) begin
        errors++;
        $display("FAIL row%0d_outputs: got=%b expected=%b", i, act, vq[i].ex);
      end
      checks++;
      if ((mem_read && mem_write) || (mem_read && reg_write)) begin
        errors++;
        $display("FAIL row%0d_exclusive: mem_read=%b mem_write=%b reg_write=%b expected no overlap", i, mem_read, mem_write, reg_write);
      end
    end
    lat(OP_LW, 5, "lw");
    lat(OP_SW, 4, "sw");
    lat(OP_R, 4, "r");
    lat(OP_ADDI, 4, "addi");
    lat(OP_BEQ, 3, "beq");
    lat(OP_J, 3, "j");
    lat(6'b111111, 2, "illegal");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
